ahb_mux_m2s: RTL and testbench



---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/ahb_arbiter.sv | 83 ++++++++
 rtl/ahb_mux_m2s.sv | 137 +++++++++++++
 tb/tb_ahb_mux_m2s.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB types for the master-to-slave interconnect slice: transfer and
// burst encodings, master indices and the burst length helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_e;

  // Address-phase / data-phase owner encoding, matches the HMASTER output.
  typedef logic [1:0] master_idx_t;

  localparam master_idx_t MST_DEFAULT = 2'd0;
  localparam master_idx_t MST_M1      = 2'd1;
  localparam master_idx_t MST_M2      = 2'd2;

  // Beats in a fixed-length burst; 0 means "not fixed length" (SINGLE, INCR).
  function automatic logic [4:0] burst_beats(input hburst_e burst);
    case (burst)
      WRAP4,  INCR4:  burst_beats = 5'd4;
      WRAP8,  INCR8:  burst_beats = 5'd8;
      WRAP16, INCR16: burst_beats = 5'd16;
      default:        burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter.sv
// Two-master round-robin AHB arbiter with a default master. Holds the grant
// through locked transfers, fixed-length bursts and requested INCR bursts,
// and pre-grants the next owner during the last beat of a fixed burst.
module ahb_arbiter
  import ahb_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic        req_m1,
  input  logic        req_m2,
  input  master_idx_t owner,
  input  htrans_e     owner_trans,
  input  hburst_e     owner_burst,
  input  logic        owner_lock,
  input  logic        owner_busreq,
  output master_idx_t grant
);

  master_idx_t grant_q;
  master_idx_t grant_d;
  master_idx_t rr_ptr_q;
  logic [3:0]  burst_left_q;
  logic [3:0]  burst_left_d;
  logic [4:0]  beats;
  logic        arb_open;

  assign beats = burst_beats(owner_burst);
  assign grant = grant_q;

  // Decide whether the current owner may be replaced at the next ready edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    arb_open = 1'b1;
    if (owner != MST_DEFAULT) begin
      arb_open = !owner_lock
              && !(owner_trans == NONSEQ && beats != 5'd0)
              && (burst_left_q == 4'd0 || (burst_left_q == 4'd1 && owner_trans == SEQ))
              && (owner_burst != INCR || !owner_busreq || owner_trans == IDLE);
    end
  end

  // Pick the next grant: single requester wins, a tie goes to the master the
  // pointer does not name, nobody requesting parks the bus on the default.
  always_comb begin
    grant_d = grant_q;
    if (arb_open) begin
      case ({req_m1, req_m2})
        2'b10:   grant_d = MST_M1;
        2'b01:   grant_d = MST_M2;
        2'b11:   grant_d = (rr_ptr_q == MST_M1) ? MST_M2 : MST_M1;
        default: grant_d = MST_DEFAULT;
      endcase
    end
  end

  // Remaining-beat counter: a NONSEQ reloads it, each SEQ beat counts it down.
  always_comb begin
    burst_left_d = burst_left_q;
    if (owner_trans == NONSEQ) begin
      burst_left_d = (beats == 5'd0) ? 4'd0 : 4'(beats - 5'd1);
    end else if (owner_trans == SEQ && burst_left_q != 4'd0) begin
      burst_left_d = burst_left_q - 4'd1;
    end
  end

  // Arbitration state; everything freezes while the bus is stalled.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (HRESET) begin
      grant_q      <= MST_DEFAULT;
      rr_ptr_q     <= MST_M2;
      burst_left_q <= 4'd0;
    end else if (HREADY) begin
      grant_q      <= grant_d;
      burst_left_q <= burst_left_d;
      if (arb_open && grant_d != MST_DEFAULT) begin
        rr_ptr_q <= grant_d;
      end
    end
  end

endmodule

// File: rtl/ahb_mux_m2s.sv
// Master-to-slave side of the AHB interconnect: arbitrates M1/M2/default,
// muxes address/control from the address-phase owner and HWDATA from the
// data-phase owner.
module ahb_mux_m2s
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_BITS  = 32,
  parameter int AHB_DATA_BITS  = 32,
  parameter int AHB_TRANS_BITS = 2,
  parameter int AHB_SIZE_BITS  = 3,
  parameter int AHB_BURST_BITS = 3
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HBUSREQ_M1,
  input  logic                      HBUSREQ_M2,
  input  logic                      HLOCK_M1,
  input  logic                      HLOCK_M2,
  input  logic [AHB_ADDR_BITS-1:0]  HADDR_M1,
  input  logic [AHB_TRANS_BITS-1:0] HTRANS_M1,
  input  logic                      HWRITE_M1,
  input  logic [AHB_SIZE_BITS-1:0]  HSIZE_M1,
  input  logic [AHB_BURST_BITS-1:0] HBURST_M1,
  input  logic [AHB_DATA_BITS-1:0]  HWDATA_M1,
  input  logic [AHB_ADDR_BITS-1:0]  HADDR_M2,
  input  logic [AHB_TRANS_BITS-1:0] HTRANS_M2,
  input  logic                      HWRITE_M2,
  input  logic [AHB_SIZE_BITS-1:0]  HSIZE_M2,
  input  logic [AHB_BURST_BITS-1:0] HBURST_M2,
  input  logic [AHB_DATA_BITS-1:0]  HWDATA_M2,
  input  logic                      HREADY,
  output logic                      HGRANT_M1,
  output logic                      HGRANT_M2,
  output logic [1:0]                HMASTER,
  output logic                      HMASTLOCK,
  output logic [AHB_ADDR_BITS-1:0]  HADDR,
  output logic [AHB_TRANS_BITS-1:0] HTRANS,
  output logic                      HWRITE,
  output logic [AHB_SIZE_BITS-1:0]  HSIZE,
  output logic [AHB_BURST_BITS-1:0] HBURST,
  output logic [AHB_DATA_BITS-1:0]  HWDATA
);

  master_idx_t grant;
  master_idx_t hmaster_q;
  master_idx_t data_owner_q;
  logic        hmastlock_q;
  logic        grant_lock;
  logic        owner_lock;
  logic        owner_busreq;

  assign HGRANT_M1 = (grant == MST_M1);
  assign HGRANT_M2 = (grant == MST_M2);
  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

  // Lock request of the granted master and lock/request of the current owner.
  always_comb begin
    grant_lock   = 1'b0;
    owner_lock   = 1'b0;
    owner_busreq = 1'b0;
    if (grant == MST_M1)     grant_lock = HLOCK_M1;
    if (grant == MST_M2)     grant_lock = HLOCK_M2;
    if (hmaster_q == MST_M1) begin
      owner_lock   = HLOCK_M1;
      owner_busreq = HBUSREQ_M1;
    end
    if (hmaster_q == MST_M2) begin
      owner_lock   = HLOCK_M2;
      owner_busreq = HBUSREQ_M2;
    end
  end

  ahb_arbiter u_arbiter (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HREADY       (HREADY),
    .req_m1       (HBUSREQ_M1),
    .req_m2       (HBUSREQ_M2),
    .owner        (hmaster_q),
    .owner_trans  (htrans_e'(HTRANS[1:0])),
    .owner_burst  (hburst_e'(HBURST[2:0])),
    .owner_lock   (owner_lock),
    .owner_busreq (owner_busreq),
    .grant        (grant)
  );

  // Phase pipeline: grant -> address owner -> data owner, advancing on HREADY.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hmaster_q    <= MST_DEFAULT;
      data_owner_q <= MST_DEFAULT;
      hmastlock_q  <= 1'b0;
    end else if (HREADY) begin
      data_owner_q <= hmaster_q;
      hmaster_q    <= grant;
      hmastlock_q  <= grant_lock;
    end
  end

  // Address/control mux; the default master issues IDLE with everything zero.
  always_comb begin
    HADDR  = '0;
    HTRANS = AHB_TRANS_BITS'(IDLE);
    HWRITE = 1'b0;
    HSIZE  = '0;
    HBURST = '0;
    case (hmaster_q)
      MST_M1: begin
        HADDR  = HADDR_M1;
        HTRANS = HTRANS_M1;
        HWRITE = HWRITE_M1;
        HSIZE  = HSIZE_M1;
        HBURST = HBURST_M1;
      end
      MST_M2: begin
        HADDR  = HADDR_M2;
        HTRANS = HTRANS_M2;
        HWRITE = HWRITE_M2;
        HSIZE  = HSIZE_M2;
        HBURST = HBURST_M2;
      end
      default: ;
    endcase
  end

  // Write-data mux driven by the data-phase owner.
  always_comb begin
    HWDATA = '0;
    case (data_owner_q)
      MST_M1:  HWDATA = HWDATA_M1;
      MST_M2:  HWDATA = HWDATA_M2;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_mux_m2s.sv
// Bench for ahb_mux_m2s: per-cycle vector table with hand-derived grant /
// owner expectations, expected bus values queued at drive time and compared
// at the falling edge, plus reset sequences.
`timescale 1ns/1ps
module tb_ahb_mux_m2s;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2, HREADY;
  logic [31:0] HADDR_M1, HADDR_M2, HWDATA_M1, HWDATA_M2;
  logic [1:0]  HTRANS_M1, HTRANS_M2;
  logic        HWRITE_M1, HWRITE_M2;
  logic [2:0]  HSIZE_M1, HSIZE_M2, HBURST_M1, HBURST_M2;
  logic        HGRANT_M1, HGRANT_M2, HMASTLOCK, HWRITE;
  logic [1:0]  HMASTER, HTRANS;
  logic [31:0] HADDR, HWDATA;
  logic [2:0]  HSIZE, HBURST;

  always #5 HCLK = ~HCLK;

  ahb_mux_m2s dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ_M1(HBUSREQ_M1), .HBUSREQ_M2(HBUSREQ_M2),
    .HLOCK_M1(HLOCK_M1), .HLOCK_M2(HLOCK_M2),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HBURST_M1(HBURST_M1), .HWDATA_M1(HWDATA_M1),
    .HADDR_M2(HADDR_M2), .HTRANS_M2(HTRANS_M2), .HWRITE_M2(HWRITE_M2),
    .HSIZE_M2(HSIZE_M2), .HBURST_M2(HBURST_M2), .HWDATA_M2(HWDATA_M2),
    .HREADY(HREADY),
    .HGRANT_M1(HGRANT_M1), .HGRANT_M2(HGRANT_M2), .HMASTER(HMASTER),
    .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA)
  );

  // One bus cycle: rst pulses reset before it; g1..mlock are the expected
  // registered state seen during this cycle.
  typedef struct {
    logic        rst;
    logic        req1, req2, lk1, lk2, rdy;
    logic [1:0]  t1;
    logic [2:0]  b1;
    logic [31:0] a1;
    logic [1:0]  t2;
    logic [2:0]  b2;
    logic [31:0] a2;
    logic        g1, g2;
    logic [1:0]  mst, dn;
    logic        mlock;
  } vec_t;

  typedef struct {
    logic        g1, g2, mlock, hwrite;
    logic [1:0]  mst, htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] haddr, hwdata;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] wdata1(input int i);
    return 32'hD100_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] wdata2(input int i);
    return 32'hD200_0000 | 32'(i);
  endfunction

  // M1 always writes words, M2 always reads halfwords, so owner shows in HWRITE/HSIZE.
  task automatic drive(input vec_t v, input int i);
    HBUSREQ_M1 = v.req1; HBUSREQ_M2 = v.req2;
    HLOCK_M1   = v.lk1;  HLOCK_M2   = v.lk2;
    HREADY     = v.rdy;
    HTRANS_M1 = v.t1; HBURST_M1 = v.b1; HADDR_M1 = v.a1;
    HWRITE_M1 = 1'b1; HSIZE_M1 = 3'd2; HWDATA_M1 = wdata1(i);
    HTRANS_M2 = v.t2; HBURST_M2 = v.b2; HADDR_M2 = v.a2;
    HWRITE_M2 = 1'b0; HSIZE_M2 = 3'd1; HWDATA_M2 = wdata2(i);
  endtask

  function automatic exp_t expect_of(input vec_t v, input int i);
    exp_t e;
    e.g1 = v.g1; e.g2 = v.g2; e.mst = v.mst; e.mlock = v.mlock;
    e.haddr = 32'h0; e.htrans = IDLE; e.hburst = 3'd0; e.hwrite = 1'b0; e.hsize = 3'd0;
    if (v.mst == 2'd1) begin
      e.haddr = v.a1; e.htrans = v.t1; e.hburst = v.b1; e.hwrite = 1'b1; e.hsize = 3'd2;
    end else if (v.mst == 2'd2) begin
      e.haddr = v.a2; e.htrans = v.t2; e.hburst = v.b2; e.hwrite = 1'b0; e.hsize = 3'd1;
    end
    e.hwdata = (v.dn == 2'd1) ? wdata1(i) : (v.dn == 2'd2) ? wdata2(i) : 32'h0;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    check({tag, " HGRANT_M1"}, 32'(HGRANT_M1), 32'(e.g1));
    check({tag, " HGRANT_M2"}, 32'(HGRANT_M2), 32'(e.g2));
    check({tag, " grant_onehot"}, 32'(HGRANT_M1 & HGRANT_M2), 32'h0);
    check({tag, " HMASTER"}, 32'(HMASTER), 32'(e.mst));
    check({tag, " HMASTLOCK"}, 32'(HMASTLOCK), 32'(e.mlock));
    check({tag, " HADDR"}, HADDR, e.haddr);
    check({tag, " HTRANS"}, 32'(HTRANS), 32'(e.htrans));
    check({tag, " HBURST"}, 32'(HBURST), 32'(e.hburst));
    check({tag, " HWRITE"}, 32'(HWRITE), 32'(e.hwrite));
    check({tag, " HSIZE"}, 32'(HSIZE), 32'(e.hsize));
    check({tag, " HWDATA"}, HWDATA, e.hwdata);
  endtask

  // Two reset edges with random inputs; optionally verify the reset state.
  task automatic do_reset(input bit verify);
    HRESET = 1'b1;
    HBUSREQ_M1 = 1'($urandom()); HBUSREQ_M2 = 1'($urandom());
    HLOCK_M1 = 1'($urandom()); HLOCK_M2 = 1'($urandom()); HREADY = 1'($urandom());
    HADDR_M1 = $urandom(); HTRANS_M1 = 2'($urandom()); HWRITE_M1 = 1'($urandom());
    HSIZE_M1 = 3'($urandom()); HBURST_M1 = 3'($urandom()); HWDATA_M1 = $urandom();
    HADDR_M2 = $urandom(); HTRANS_M2 = 2'($urandom()); HWRITE_M2 = 1'($urandom());
    HSIZE_M2 = 3'($urandom()); HBURST_M2 = 3'($urandom()); HWDATA_M2 = $urandom();
    repeat (2) @(posedge HCLK);
    if (verify) begin
      @(negedge HCLK);
      check("reset HGRANT_M1", 32'(HGRANT_M1), 32'h0);
      check("reset HGRANT_M2", 32'(HGRANT_M2), 32'h0);
      check("reset HMASTER", 32'(HMASTER), 32'h0);
      check("reset HTRANS", 32'(HTRANS), 32'(IDLE));
      check("reset HADDR", HADDR, 32'h0);
      check("reset HWDATA", HWDATA, 32'h0);
      check("reset HMASTLOCK", 32'(HMASTLOCK), 32'h0);
      @(posedge HCLK);
    end
    #1 HRESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t tmp;
    // rst req1 req2 lk1 lk2 rdy | M1 trans/burst/addr | M2 trans/burst/addr | g1 g2 mst dn mlock
    // M1 single write: grant N+1, HMASTER N+2, HWDATA N+3.
    vecs.push_back('{1, 1,0,0,0,1, NONSEQ,SINGLE,32'h1000, IDLE,SINGLE,32'h0, 0,0, 0,0,0});
    vecs.push_back('{0, 0,0,0,0,1, NONSEQ,SINGLE,32'h1000, IDLE,SINGLE,32'h0, 1,0, 0,0,0});
    vecs.push_back('{0, 0,0,0,0,1, NONSEQ,SINGLE,32'h1000, IDLE,SINGLE,32'h0, 0,0, 1,0,0});
    vecs.push_back('{0, 0,0,0,0,1, IDLE,  SINGLE,32'h1000, IDLE,SINGLE,32'h0, 0,0, 0,1,0});
    // Tie from reset: M1 first, then alternating.
    vecs.push_back('{1, 1,1,0,0,1, NONSEQ,SINGLE,32'h3000, NONSEQ,SINGLE,32'h4000, 0,0, 0,0,0});
    vecs.push_back('{0, 1,1,0,0,1, NONSEQ,SINGLE,32'h3000, NONSEQ,SINGLE,32'h4000, 1,0, 0,0,0});
    vecs.push_back('{0, 1,1,0,0,1, NONSEQ,SINGLE,32'h3000, NONSEQ,SINGLE,32'h4000, 0,1, 1,0,0});
    vecs.push_back('{0, 1,1,0,0,1, NONSEQ,SINGLE,32'h3000, NONSEQ,SINGLE,32'h4000, 1,0, 2,1,0});
    vecs.push_back('{0, 1,1,0,0,1, NONSEQ,SINGLE,32'h3000, NONSEQ,SINGLE,32'h4000, 0,1, 1,2,0});
    // M1 INCR4 with M2 waiting; three wait states on the 0x200C beat.
    vecs.push_back('{1, 1,0,0,0,1, NONSEQ,INCR4,32'h2000, IDLE,SINGLE,32'h5000, 0,0, 0,0,0});
    vecs.push_back('{0, 1,0,0,0,1, NONSEQ,INCR4,32'h2000, IDLE,SINGLE,32'h5000, 1,0, 0,0,0});
    vecs.push_back('{0, 0,1,0,0,1, NONSEQ,INCR4,32'h2000, NONSEQ,SINGLE,32'h5000, 1,0, 1,0,0});
    vecs.push_back('{0, 0,1,0,0,1, SEQ,INCR4,32'h2004, NONSEQ,SINGLE,32'h5000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,1, SEQ,INCR4,32'h2008, NONSEQ,SINGLE,32'h5000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,0, SEQ,INCR4,32'h200C, NONSEQ,SINGLE,32'h5000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,0, SEQ,INCR4,32'h200C, NONSEQ,SINGLE,32'h5000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,0, SEQ,INCR4,32'h200C, NONSEQ,SINGLE,32'h5000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,1, SEQ,INCR4,32'h200C, NONSEQ,SINGLE,32'h5000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,1, IDLE,INCR4,32'h200C, NONSEQ,SINGLE,32'h5000, 0,1, 1,1,0});
    vecs.push_back('{0, 0,0,0,0,1, IDLE,INCR4,32'h200C, NONSEQ,SINGLE,32'h5000, 0,1, 2,1,0});
    vecs.push_back('{0, 0,0,0,0,1, IDLE,INCR4,32'h200C, IDLE,SINGLE,32'h5000, 0,0, 2,2,0});
    vecs.push_back('{0, 0,0,0,0,1, IDLE,INCR4,32'h200C, IDLE,SINGLE,32'h5000, 0,0, 0,2,0});
    // M1 locked over two singles while M2 requests.
    vecs.push_back('{1, 1,0,1,0,1, NONSEQ,SINGLE,32'h6000, IDLE,SINGLE,32'h7000, 0,0, 0,0,0});
    vecs.push_back('{0, 1,0,1,0,1, NONSEQ,SINGLE,32'h6000, IDLE,SINGLE,32'h7000, 1,0, 0,0,0});
    vecs.push_back('{0, 1,1,1,0,1, NONSEQ,SINGLE,32'h6000, NONSEQ,SINGLE,32'h7000, 1,0, 1,0,1});
    vecs.push_back('{0, 1,1,1,0,1, NONSEQ,SINGLE,32'h6004, NONSEQ,SINGLE,32'h7000, 1,0, 1,1,1});
    vecs.push_back('{0, 0,1,0,0,1, IDLE,SINGLE,32'h6004, NONSEQ,SINGLE,32'h7000, 1,0, 1,1,1});
    vecs.push_back('{0, 0,1,0,0,1, IDLE,SINGLE,32'h6004, NONSEQ,SINGLE,32'h7000, 0,1, 1,1,0});
    vecs.push_back('{0, 0,0,0,0,1, IDLE,SINGLE,32'h6004, NONSEQ,SINGLE,32'h7000, 0,1, 2,1,0});
    vecs.push_back('{0, 0,0,0,0,1, IDLE,SINGLE,32'h6004, IDLE,SINGLE,32'h7000, 0,0, 2,2,0});
    // Undefined-length INCR held while M1 requests, released when it drops.
    vecs.push_back('{1, 1,0,0,0,1, NONSEQ,INCR,32'h8000, IDLE,SINGLE,32'h9000, 0,0, 0,0,0});
    vecs.push_back('{0, 1,0,0,0,1, NONSEQ,INCR,32'h8000, IDLE,SINGLE,32'h9000, 1,0, 0,0,0});
    vecs.push_back('{0, 1,1,0,0,1, NONSEQ,INCR,32'h8000, NONSEQ,SINGLE,32'h9000, 1,0, 1,0,0});
    vecs.push_back('{0, 1,1,0,0,1, SEQ,INCR,32'h8004, NONSEQ,SINGLE,32'h9000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,1, SEQ,INCR,32'h8008, NONSEQ,SINGLE,32'h9000, 1,0, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,1, IDLE,INCR,32'h8008, NONSEQ,SINGLE,32'h9000, 0,1, 1,1,0});
    vecs.push_back('{0, 0,1,0,0,1, IDLE,INCR,32'h8008, NONSEQ,SINGLE,32'h9000, 0,1, 2,1,0});

    do_reset(1'b1);

    foreach (vecs[i]) begin
      exp_t e;
      if (vecs[i].rst) do_reset(1'b0);
      drive(vecs[i], i);
      sb_q.push_back(expect_of(vecs[i], i));
      @(negedge HCLK);
      if (sb_q.size() == 0) begin
        check($sformatf("v%0d scoreboard_empty", i), 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        compare($sformatf("v%0d", i), e);
      end
      @(posedge HCLK);
      #1;
    end

    // Reset while a locked M1 owns the address phase, with HREADY low.
    do_reset(1'b0);
    tmp = '{0, 1,0,1,0,1, NONSEQ,SINGLE,32'hA000, IDLE,SINGLE,32'h0, 0,0, 0,0,0};
    drive(tmp, 100);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("preabort HMASTER", 32'(HMASTER), 32'h1);
    check("preabort HMASTLOCK", 32'(HMASTLOCK), 32'h1);
    HRESET = 1'b1;
    HREADY = 1'b0;
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    check("abort HGRANT_M1", 32'(HGRANT_M1), 32'h0);
    check("abort HMASTER", 32'(HMASTER), 32'h0);
    check("abort HMASTLOCK", 32'(HMASTLOCK), 32'h0);
    check("abort HTRANS", 32'(HTRANS), 32'(IDLE));
    check("abort HWDATA", HWDATA, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
